// File: rtl/jk_seq_pkg.sv
// Shared opcode and FSM state encodings for the JK bank sequencer.
package jk_seq_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_CLEAR  = 3'd1,
    OP_SET    = 3'd2,
    OP_LOAD   = 3'd3,
    OP_TOGGLE = 3'd4,
    OP_INC    = 3'd5,
    OP_DEC    = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low reset.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command sequencer that drives a WIDTH-bit JK flip-flop bank, repeating one
// operation for cmd_rep+1 cycles per accepted command.
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_rep,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e           state, state_nxt;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt;
  logic             wrap_q;
  logic             accept;

  // Bit i toggles when every lower bit is 1 (count up) or 0 (count down).
  function automatic logic [WIDTH-1:0] step_mask(input logic [WIDTH-1:0] v,
                                                 input logic down);
    logic [WIDTH-1:0] t;
    t    = '0;
    t[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      t[i] = t[i-1] & (v[i-1] ^ down);
    end
    return t;
  endfunction

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign wrap      = wrap_q;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      op_q   <= OP_HOLD;
      data_q <= '0;
      cnt    <= '0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      wrap_q <= (state == ST_EXEC) &&
                (((op_q == OP_INC) && (&q)) || ((op_q == OP_DEC) && !(|q)));
      if (accept) begin
        op_q   <= op_e'(cmd_op);
        data_q <= cmd_data;
        cnt    <= cmd_rep;
      end else if (state == ST_EXEC) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    j_vec     = '0;
    k_vec     = '0;
    case (state)
      ST_IDLE: if (cmd_valid) state_nxt = ST_EXEC;
      ST_EXEC: if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (state == ST_EXEC) begin
      case (op_q)
        OP_CLEAR:  k_vec = '1;
        OP_SET:    j_vec = '1;
        OP_LOAD: begin
          j_vec = data_q;
          k_vec = ~data_q;
        end
        OP_TOGGLE: begin
          j_vec = data_q;
          k_vec = data_q;
        end
        OP_INC: begin
          j_vec = step_mask(q, 1'b0);
          k_vec = step_mask(q, 1'b0);
        end
        OP_DEC: begin
          j_vec = step_mask(q, 1'b1);
          k_vec = step_mask(q, 1'b1);
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_vec[g]),
      .k   (k_vec[g]),
      .q   (q[g])
    );
  end

endmodule

// File: doc/jk_seq_ctrl.md
# jk_seq_ctrl

Command-driven sequencer for a WIDTH-bit bank of JK flip-flops. It accepts one operation at a time over a valid/ready handshake and computes the per-bit J/K drive each cycle to apply that operation to the bank: hold, clear, set, load, toggle, increment or decrement. The operation repeats for a programmed number of cycles. The block sits between control logic and the JK storage bank and owns that bank.

## Interface
Parameters:
- WIDTH, 4, number of JK flip-flops in the bank
- CNT_W, 4, width of the repeat count

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command; high only in IDLE
- cmd_op  input  3  opcode: HOLD=0, CLEAR=1, SET=2, LOAD=3, TOGGLE=4, INC=5, DEC=6; 7 is reserved and treated as HOLD
- cmd_data  input  WIDTH  LOAD value, or the TOGGLE bit mask
- cmd_rep  input  CNT_W  number of applications minus 1
- q  output  WIDTH  bank state
- j_vec  output  WIDTH  J drive applied to the bank (observable)
- k_vec  output  WIDTH  K drive applied to the bank (observable)
- busy  output  1  high in EXEC or DONE
- done  output  1  one-cycle pulse when a command completes
- wrap  output  1  one-cycle pulse on INC overflow or DEC underflow

## Operation
- FSM states: IDLE, EXEC, DONE.
  - IDLE -> EXEC when cmd_valid && cmd_ready. At that edge op, data and cnt=cmd_rep are latched.
  - EXEC: on each edge the bank applies j_vec/k_vec and cnt decrements. On the edge where cnt==0, go to DONE.
  - DONE -> IDLE unconditionally after one cycle.
- j_vec/k_vec are combinational from the latched op, the latched data and the current q:
  - HOLD: j=0, k=0
  - CLEAR: j=0, k=all ones
  - SET: j=all ones, k=0
  - LOAD: j=data, k=~data
  - TOGGLE: j=k=data
  - INC: j=k=t, where t[0]=1 and t[i]=&q[i-1:0]
  - DEC: j=k=t, where t[0]=1 and t[i]=~|q[i-1:0]
- Outside EXEC, j_vec=k_vec=0, so the bank holds.
- Each bank bit follows the standard JK rule: 00 hold, 01 reset, 10 set, 11 toggle.
- Arithmetic is modulo 2^WIDTH.
- wrap is registered. It goes high for the cycle after any edge that applies INC with q all ones, or DEC with q zero. It can pulse several times within one command.
- cmd_valid is ignored while busy. A command is never queued.
- Reset (rst=0) takes effect immediately regardless of clk:
  - q=0, state=IDLE, cnt=0, done=0, wrap=0
  - therefore cmd_ready=1, busy=0, j_vec=k_vec=0
- Reset during EXEC or DONE aborts the command. No done pulse is produced, and the partial q is discarded (cleared to 0).
- Reset deassertion is treated as synchronous to clk by the system. The first accept is possible at the first clk edge after rst rises.

## Timing
- Accept at edge E0. q updates at edges E1 through E(rep+1).
- done is high in the cycle following E(rep+1).
- cmd_ready rises after E(rep+2). The minimum command-to-command spacing is rep+3 cycles.
- cmd_rep=0 gives exactly one application. The maximum is 2^CNT_W applications.
- A q change is visible in the same cycle that wrap or done for that edge is visible.

## Structure
- Package jk_seq_pkg holds:
  - the opcode constants (OP_HOLD through OP_DEC, plus the reserved value 7)
  - the FSM state encoding (IDLE, EXEC, DONE)
- Sub-module jk_cell: a single JK flip-flop with ports clk, rst (async active-low), j, k, q. It is instantiated WIDTH times via generate to form the bank.
- Toggle-mask generation (INC/DEC) lives in jk_seq_ctrl as a combinational function.

## Test plan
All scenarios use WIDTH=4 and CNT_W=4.
- Reset: pull rst low mid-cycle with q=4'b1011 -> q=0000, cmd_ready=1, done=0 and wrap=0 immediately, without waiting for a clk edge.
- LOAD data=1010 rep=0 -> q=1010 after E1; done high for exactly one cycle after E1; cmd_ready back after E2; j_vec=1010 and k_vec=0101 during EXEC.
- INC from q=1110 with rep=2 -> q sequence 1111, 0000, 0001; wrap pulses once, in the cycle after the 1111->0000 edge; done after the third update.
- DEC from q=0000 with rep=0 -> q=1111 and wrap pulses. Then TOGGLE data=0101 with rep=1 -> q=1010, then 1111.
- Busy rejection: hold cmd_valid high with CLEAR throughout an INC rep=3 -> CLEAR is accepted only when cmd_ready returns (E5 relative to the INC accept); the INC results are unaffected.
- Mid-operation reset: start INC from 0000 with rep=7 and assert rst after 3 updates (q=0011) -> q=0000 and IDLE; no done pulse at any later time; the next command is accepted normally after rst is released.
